// File: rtl/dff_rr_share_ctrl.sv
// dff_rr_share_ctrl
//   Round-robin owner of a single shared DATA_W-wide capture register.
//   One requester at a time is granted. While granted, its data word is
//   clocked into the shared register on each rising edge for up to
//   HOLD_CYCLES edges, or fewer if it drops its request first. Every grant
//   ends with a mandatory one-cycle RELEASE gap.
//
// Ports
//   inClk     : clock, all state changes on the rising edge
//   inRstN    : asynchronous active-low reset
//   inReq     : level-sensitive request, one bit per requester
//   inData    : requester words, requester i at [i*DATA_W +: DATA_W]
//   outGnt    : registered one-hot grant (or zero)
//   outOwner  : registered index of the current/last owner
//   outQ      : shared capture register
//   outValid  : high for the cycle after each capture edge
//   outBusy   : high whenever the controller is not in IDLE
//
// States
//   IDLE    | no owner; arbitrate on any request at the next edge
//   GRANT   | owner fixed; capture its data each edge until hold expires
//           | or the owner drops its request
//   RELEASE | one-cycle gap; advance the round-robin pointer past the owner

module dff_rr_share_ctrl #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    inClk,
    input  logic                    inRstN,
    input  logic [N_REQ-1:0]        inReq,
    input  logic [N_REQ*DATA_W-1:0] inData,
    output logic [N_REQ-1:0]        outGnt,
    output logic [2:0]              outOwner,
    output logic [DATA_W-1:0]       outQ,
    output logic                    outValid,
    output logic                    outBusy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } stateType;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    stateType              state;
    stateType              stateNext;
    logic [2:0]            rrPtr;
    logic [2:0]            rrPtrNext;
    logic [3:0]            holdLeft;
    logic [3:0]            holdLeftNext;
    logic [N_REQ-1:0]      gntNext;
    logic [2:0]            ownerNext;
    logic [DATA_W-1:0]     qNext;
    logic                  validNext;

    logic [2:0]            winner;
    logic [N_REQ-1:0]      scanReq;
    logic                  scanFound;
    int                    scanIdx;

    logic [N_REQ-1:0]      ownerMatchReq;
    logic [N_REQ:0][DATA_W-1:0] ownerDataChain;
    logic                  ownerReq;
    logic [DATA_W-1:0]     ownerData;

    // Owner's request bit and data word, selected by a constant-index
    // AND/OR mux so the selection never depends on out-of-range indices.
    assign ownerDataChain[0] = '0;
    for (genvar i = 0; i < N_REQ; i++) begin : gOwnerSel
        assign ownerMatchReq[i]    = inReq[i] & (outOwner == 3'(i));
        assign ownerDataChain[i+1] = ownerDataChain[i] |
                                     ((outOwner == 3'(i)) ? inData[i*DATA_W +: DATA_W] : '0);
    end
    assign ownerReq  = |ownerMatchReq;
    assign ownerData = ownerDataChain[N_REQ];

    // Rotate the request vector so the pointer position sits at bit 0,
    // then take the first set bit; its offset from the pointer (mod N_REQ)
    // is the winner.
    always_comb begin
        winner    = '0;
        scanFound = 1'b0;
        scanIdx   = 0;
        scanReq   = (inReq >> rrPtr) | (inReq << (N_REQ - int'(rrPtr)));
        for (int k = 0; k < N_REQ; k++) begin
            if (!scanFound && scanReq[0]) begin
                scanFound = 1'b1;
                scanIdx   = int'(rrPtr) + k;
                if (scanIdx >= N_REQ) begin
                    scanIdx = scanIdx - N_REQ;
                end
                winner = 3'(scanIdx);
            end
            scanReq = scanReq >> 1;
        end
    end

    always_comb begin
        stateNext    = state;
        rrPtrNext    = rrPtr;
        holdLeftNext = holdLeft;
        gntNext      = outGnt;
        ownerNext    = outOwner;
        qNext        = outQ;
        validNext    = 1'b0;

        case (state)
            IDLE: begin
                if (|inReq) begin
                    gntNext      = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                    ownerNext    = winner;
                    holdLeftNext = HOLD_LOAD;
                    stateNext    = GRANT;
                end
            end

            GRANT: begin
                if (ownerReq) begin
                    qNext     = ownerData;
                    validNext = 1'b1;
                    if (holdLeft == 4'd0) begin
                        gntNext   = '0;
                        stateNext = RELEASE;
                    end else begin
                        holdLeftNext = holdLeft - 4'd1;
                    end
                end else begin
                    // Owner let go: no capture on this edge, register holds.
                    gntNext   = '0;
                    stateNext = RELEASE;
                end
            end

            RELEASE: begin
                if (int'(outOwner) == N_REQ - 1) begin
                    rrPtrNext = '0;
                end else begin
                    rrPtrNext = outOwner + 3'd1;
                end
                stateNext = IDLE;
            end

            default: begin
                gntNext   = '0;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state    <= IDLE;
            rrPtr    <= '0;
            holdLeft <= '0;
            outGnt   <= '0;
            outOwner <= '0;
            outQ     <= '0;
            outValid <= 1'b0;
        end else begin
            state    <= stateNext;
            rrPtr    <= rrPtrNext;
            holdLeft <= holdLeftNext;
            outGnt   <= gntNext;
            outOwner <= ownerNext;
            outQ     <= qNext;
            outValid <= validNext;
        end
    end

    assign outBusy = (state != IDLE);

endmodule

// File: tb/tb_dff_rr_share_ctrl.sv
// Bench for dff_rr_share_ctrl: expected captures are queued when stimulus
// is driven and popped whenever outValid is seen after a rising edge.

module tb_dff_rr_share_ctrl;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [2:0]   owner;
        logic [W-1:0] data;
    } capType;

    logic             clk = 1'b0;
    logic             rstN;
    logic [N-1:0]     req;
    logic [N*W-1:0]   data;
    logic [N-1:0]     gnt;
    logic [2:0]       owner;
    logic [W-1:0]     q;
    logic             valid;
    logic             busy;

    capType           expQ[$];
    capType           popped;
    capType           pushed;
    logic [W-1:0]     modelQ;
    int               testsRun = 0;
    int               testsFailed = 0;

    dff_rr_share_ctrl #(.N_REQ(N), .DATA_W(W), .HOLD_CYCLES(2)) dut (
        .inClk    (clk),
        .inRstN   (rstN),
        .inReq    (req),
        .inData   (data),
        .outGnt   (gnt),
        .outOwner (owner),
        .outQ     (q),
        .outValid (valid),
        .outBusy  (busy)
    );

    always #20 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushCap(input int who, input logic [W-1:0] d, input int n);
        capType c;
        c.owner = 3'(who);
        c.data  = d;
        for (int i = 0; i < n; i++) expQ.push_back(c);
    endtask

    // Capture monitor and grant sanity, sampled just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (valid) begin
            if (expQ.size() == 0) begin
                checkVal("unexpected_capture", 32'(valid), 32'd0);
            end else begin
                popped = expQ.pop_front();
                checkVal("cap_q", 32'(q), 32'(popped.data));
                checkVal("cap_owner", 32'(owner), 32'(popped.owner));
                modelQ = popped.data;
            end
        end
        checkVal("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    end

    // Between edges the shared register must match the last expected capture.
    always @(negedge clk) begin
        checkVal("q_stable", 32'(q), 32'(modelQ));
    end

    initial begin
        rstN   = 1'b0;
        req    = '0;
        data   = '0;
        modelQ = '0;

        // 1: reset then single request
        #25;
        checkVal("rst_gnt", 32'(gnt), 32'd0);
        checkVal("rst_owner", 32'(owner), 32'd0);
        checkVal("rst_q", 32'(q), 32'd0);
        checkVal("rst_valid", 32'(valid), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        rstN = 1'b1;
        data[7:0] = 8'hA5;
        req = 4'b0001;
        pushCap(0, 8'hA5, 2);
        tick();
        checkVal("t1_gnt", 32'(gnt), 32'h1);
        checkVal("t1_busy", 32'(busy), 32'd1);
        checkVal("t1_valid0", 32'(valid), 32'd0);
        tick();
        checkVal("t1_valid1", 32'(valid), 32'd1);
        checkVal("t1_gnt_hold", 32'(gnt), 32'h1);
        tick();
        checkVal("t1_valid2", 32'(valid), 32'd1);
        checkVal("t1_gnt_off", 32'(gnt), 32'd0);
        req = '0;
        tick();
        checkVal("t1_idle_busy", 32'(busy), 32'd0);
        checkVal("t1_idle_valid", 32'(valid), 32'd0);

        // 2: all-request rotation from a fresh pointer
        rstN = 1'b0;
        modelQ = '0;
        #10;
        rstN = 1'b1;
        for (int i = 0; i < N; i++) data[i*W +: W] = W'(8'h10 + i);
        for (int k = 0; k < 5; k++) pushCap(k % N, W'(8'h10 + (k % N)), 2);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkVal("t2_gnt", 32'(gnt), 32'd1 << (k % N));
            checkVal("t2_owner", 32'(owner), 32'(k % N));
            tick();
            tick();
            checkVal("t2_gnt_off", 32'(gnt), 32'd0);
            checkVal("t2_busy_rel", 32'(busy), 32'd1);
            if (k == 4) req = '0;
            tick();
            checkVal("t2_busy_idle", 32'(busy), 32'd0);
        end

        // 3: early drop by requester 2 (pointer is at 1)
        data[2*W +: W] = 8'h3C;
        pushCap(2, 8'h3C, 1);
        req = 4'b0100;
        tick();
        checkVal("t3_gnt", 32'(gnt), 32'h4);
        tick();
        checkVal("t3_valid1", 32'(valid), 32'd1);
        req = '0;
        tick();
        checkVal("t3_drop_valid", 32'(valid), 32'd0);
        checkVal("t3_drop_q", 32'(q), 32'h3C);
        checkVal("t3_drop_gnt", 32'(gnt), 32'd0);
        checkVal("t3_rel_busy", 32'(busy), 32'd1);
        tick();
        checkVal("t3_idle_busy", 32'(busy), 32'd0);

        // 4: wrap and priority, pointer at 3
        pushCap(3, 8'h13, 2);
        pushCap(0, 8'h10, 2);
        req = 4'b1001;
        tick();
        checkVal("t4_gnt3", 32'(gnt), 32'h8);
        checkVal("t4_owner3", 32'(owner), 32'd3);
        tick();
        tick();
        tick();
        tick();
        checkVal("t4_gnt0", 32'(gnt), 32'h1);
        checkVal("t4_owner0", 32'(owner), 32'd0);
        tick();
        tick();
        req = '0;
        tick();

        // 5: pointer now 1, then reset in the middle of the grant
        pushCap(1, 8'h11, 1);
        req = 4'b0011;
        tick();
        checkVal("t5_gnt_ptr1", 32'(gnt), 32'h2);
        tick();
        checkVal("t5_valid1", 32'(valid), 32'd1);
        #10;
        rstN = 1'b0;
        modelQ = '0;
        #1;
        checkVal("t5_rst_gnt", 32'(gnt), 32'd0);
        checkVal("t5_rst_q", 32'(q), 32'd0);
        checkVal("t5_rst_valid", 32'(valid), 32'd0);
        checkVal("t5_rst_busy", 32'(busy), 32'd0);
        checkVal("t5_rst_owner", 32'(owner), 32'd0);
        req = 4'b0010;
        tick();
        rstN = 1'b1;
        pushCap(1, 8'h11, 2);
        tick();
        checkVal("t5_regrant", 32'(gnt), 32'h2);
        checkVal("t5_reowner", 32'(owner), 32'd1);
        tick();
        tick();
        req = '0;
        tick();
        checkVal("t5_idle_busy", 32'(busy), 32'd0);

        // 6: toggling data against the clock
        data[7:0] = 8'h5A;
        req = 4'b0001;
        fork
            begin
                repeat (50) begin
                    #6 data[7:0] = ~data[7:0];
                end
            end
        join_none
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            if (e == 2 || e == 3 || e == 6 || e == 7) begin
                pushed.owner = 3'd0;
                pushed.data  = data[7:0];
                expQ.push_back(pushed);
            end
            #1;
            if (e == 1 || e == 5) checkVal("t6_gnt", 32'(gnt), 32'h1);
            if (e == 4 || e == 8) checkVal("t6_valid_gap", 32'(valid), 32'd0);
            if (e == 7) req = '0;
        end
        tick();

        checkVal("sb_empty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
